fp_div_round_pack: RTL and testbench

Output stage of the single-precision floating-point divider. It takes the raw quotient mantissa from the mantissa divider, plus the sign, the biased exponent difference and the special-case flags from the operand unpacker. It normalizes the quotient, rounds it to nearest-even, detects overflow and underflow, and packs an IEEE-754 binary32 result. It is a 2-stage valid/ready pipeline that sits between the mantissa divider and the divider's result register/bus interface.

---
 rtl/fp_div_pkg.sv | 23 ++
 rtl/fp_div_round_pack_round_ne.sv | 14 +
 rtl/fp_div_round_pack.sv | 167 ++++++++++++++++
 tb/tb_fp_div_round_pack.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared constants and the stage-1 -> stage-2 register layout for the
// floating-point divider output path.
package fp_div_pkg;

    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 255;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam int FP_MANT_W  = 23;
    // Internal exponent width; must be at least EXP_W+1 of any instantiating stage.
    localparam int FP_XW      = 16;

    typedef struct packed {
        logic                    sign;
        logic signed [FP_XW-1:0] exp_n;
        logic [FP_MANT_W-1:0]    mant;
        logic                    round_up;
        logic                    inexact;
        logic                    nan;
        logic                    inf;
        logic                    zero;
    } s1_reg_t;

endpackage

// File: rtl/fp_div_round_pack_round_ne.sv
// Round-to-nearest-even decision from the kept LSB, guard bit and sticky bit.
// Shared by the divide, multiply and add output stages.
module fp_round_ne (
    input  logic i_lsb,
    input  logic i_guard,
    input  logic i_sticky,
    output logic o_round_up,
    output logic o_inexact
);

    assign o_round_up = i_guard & (i_sticky | i_lsb);
    assign o_inexact  = i_guard | i_sticky;

endmodule

// File: rtl/fp_div_round_pack.sv
// Divider output stage: normalize and round (stage 1), pack with overflow /
// underflow handling (stage 2), as a two-deep valid/ready pipeline.
module fp_div_round_pack
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [25:0]             in_q,
    input  logic                    in_sticky,
    input  logic                    in_nan,
    input  logic                    in_inf,
    input  logic                    in_zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_result,
    output logic                    out_overflow,
    output logic                    out_underflow,
    output logic                    out_inexact
);

    localparam logic signed [FP_XW-1:0] EXP_MAX_X = FP_XW'(FP_EXP_MAX);

    logic                    r_s1_valid;
    s1_reg_t                 r_s1;
    logic                    r_o_valid;
    logic [31:0]             r_result;
    logic                    r_ovf;
    logic                    r_unf;
    logic                    r_inx;

    logic                    w_s2_load;
    logic                    w_s1_load;
    logic [FP_MANT_W-1:0]    w_mant;
    logic                    w_guard;
    logic                    w_sticky;
    logic signed [EXP_W:0]   w_exp_n;
    logic                    w_round_up;
    logic                    w_inexact;
    s1_reg_t                 w_s1_next;

    logic signed [FP_XW-1:0] w_exp_s1;
    logic signed [FP_XW-1:0] w_exp_f;
    logic                    w_carry;
    logic [FP_MANT_W-1:0]    w_mant_r;
    logic                    w_unf;
    logic                    w_ovf;
    logic [31:0]             w_result;
    logic                    w_ovf_flag;
    logic                    w_unf_flag;
    logic                    w_inx_flag;

    assign w_s2_load = !r_o_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = !rst && w_s1_load;

    always_comb begin
        w_mant   = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        w_exp_n  = '0;
        if (in_q[25]) begin
            w_mant   = in_q[24:2];
            w_guard  = in_q[1];
            w_sticky = in_q[0] | in_sticky;
            w_exp_n  = {in_exp[EXP_W-1], in_exp};
        end else begin
            w_mant   = in_q[23:1];
            w_guard  = in_q[0];
            w_sticky = in_sticky;
            w_exp_n  = {in_exp[EXP_W-1], in_exp} - (EXP_W+1)'(1);
        end
    end

    fp_round_ne u_round (
        .i_lsb      (w_mant[0]),
        .i_guard    (w_guard),
        .i_sticky   (w_sticky),
        .o_round_up (w_round_up),
        .o_inexact  (w_inexact)
    );

    always_comb begin
        w_s1_next          = '0;
        w_s1_next.sign     = in_sign;
        w_s1_next.exp_n    = {{(FP_XW-EXP_W-1){w_exp_n[EXP_W]}}, w_exp_n};
        w_s1_next.mant     = w_mant;
        w_s1_next.round_up = w_round_up;
        w_s1_next.inexact  = w_inexact;
        w_s1_next.nan      = in_nan;
        w_s1_next.inf      = in_inf;
        w_s1_next.zero     = in_zero;
    end

    // A carry out of the hidden bit only happens when the mantissa is all ones,
    // in which case the rounded fraction wraps to zero by itself.
    assign {w_carry, w_mant_r} = {1'b0, r_s1.mant} + {{FP_MANT_W{1'b0}}, r_s1.round_up};
    assign w_exp_s1 = r_s1.exp_n;
    assign w_exp_f  = w_exp_s1 + $signed({{(FP_XW-1){1'b0}}, w_carry});
    assign w_unf    = w_exp_s1[FP_XW-1] || (w_exp_s1 == '0);
    assign w_ovf    = (w_exp_f >= EXP_MAX_X);

    always_comb begin
        w_result   = {r_s1.sign, w_exp_f[7:0], w_mant_r};
        w_ovf_flag = 1'b0;
        w_unf_flag = 1'b0;
        w_inx_flag = r_s1.inexact;
        if (r_s1.nan) begin
            w_result   = FP_QNAN;
            w_inx_flag = 1'b0;
        end else if (r_s1.inf) begin
            w_result   = {r_s1.sign, 8'hFF, 23'h0};
            w_inx_flag = 1'b0;
        end else if (r_s1.zero) begin
            w_result   = {r_s1.sign, 31'h0};
            w_inx_flag = 1'b0;
        end else if (w_unf) begin
            w_result   = {r_s1.sign, 31'h0};
            w_unf_flag = 1'b1;
            w_inx_flag = 1'b1;
        end else if (w_ovf) begin
            w_result   = {r_s1.sign, 8'hFF, 23'h0};
            w_ovf_flag = 1'b1;
            w_inx_flag = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
            r_o_valid  <= 1'b0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_inx      <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_o_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_result <= w_result;
                    r_ovf    <= w_ovf_flag;
                    r_unf    <= w_unf_flag;
                    r_inx    <= w_inx_flag;
                end
            end
            if (w_s1_load) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1 <= w_s1_next;
                end
            end
        end
    end

    assign out_valid     = r_o_valid;
    assign out_result    = r_result;
    assign out_overflow  = r_ovf;
    assign out_underflow = r_unf;
    assign out_inexact   = r_inx;

endmodule

// File: tb/tb_fp_div_round_pack.sv
// Randomized bench for fp_div_round_pack against a value-level rounding model
// with a FIFO scoreboard, plus directed latency, backpressure and reset cases.
module tb_fp_div_round_pack;

    localparam int EXP_W = 10;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic                    in_sign = 1'b0;
    logic signed [EXP_W-1:0] in_exp = '0;
    logic [25:0]             in_q = '0;
    logic                    in_sticky = 1'b0;
    logic                    in_nan = 1'b0;
    logic                    in_inf = 1'b0;
    logic                    in_zero = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [31:0]             out_result;
    logic                    out_overflow;
    logic                    out_underflow;
    logic                    out_inexact;

    fp_div_round_pack #(.EXP_W(EXP_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_q          (in_q),
        .in_sticky     (in_sticky),
        .in_nan        (in_nan),
        .in_inf        (in_inf),
        .in_zero       (in_zero),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [34:0] sb[$];
    logic [34:0] exp_item;
    bit          prev_hold = 1'b0;
    logic [34:0] prev_obs = '0;
    bit          acc_now = 1'b0;
    int          acc_cnt = 0;
    wire  [34:0] obs = {out_overflow, out_underflow, out_inexact, out_result};

    // {overflow, underflow, inexact, result} from the quotient value itself:
    // keep the top 24 significant bits, round the discarded remainder to
    // nearest with ties to an even kept value, then range-check the exponent.
    function automatic logic [34:0] model(input logic s, input int e_in, input logic [25:0] q,
                                          input logic st, input logic nan, input logic inf,
                                          input logic zero);
        logic [24:0] m;
        int          sh;
        int          rem;
        int          half;
        int          e;
        logic        up;
        logic        inx;
        if (nan)  return {3'b000, 32'h7FC0_0000};
        if (inf)  return {3'b000, s, 8'hFF, 23'h0};
        if (zero) return {3'b000, s, 31'h0};
        sh   = q[25] ? 2 : 1;
        m    = 25'(q >> sh);
        rem  = int'(q) & ((1 << sh) - 1);
        half = 1 << (sh - 1);
        e    = e_in - ((sh == 1) ? 1 : 0);
        up   = (rem > half) || ((rem == half) && (st || m[0]));
        inx  = (rem != 0) || st;
        if (e <= 0) return {3'b011, s, 31'h0};
        m = m + 25'(up);
        if (m == 25'h100_0000) begin
            m = 25'h080_0000;
            e = e + 1;
        end
        if (e >= 255) return {3'b101, s, 8'hFF, 23'h0};
        return {2'b00, inx, s, e[7:0], m[22:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Called with inputs settled just after a falling edge; observes the
    // handshakes that the coming rising edge will perform.
    task automatic tick();
        #1;
        if (prev_hold) chk("hold", 64'({out_valid, obs}), 64'({1'b1, prev_obs}));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", 64'(out_valid), 64'(0));
            else begin
                exp_item = sb.pop_front();
                chk("result", 64'(obs), 64'(exp_item));
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_obs  = obs;
        acc_now   = in_valid && in_ready;
        if (acc_now) begin
            sb.push_back(model(in_sign, int'($signed(in_exp)), in_q, in_sticky,
                               in_nan, in_inf, in_zero));
            acc_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input int e, input logic [25:0] q, input logic st,
                         input logic nan, input logic inf, input logic zero);
        in_valid  = 1'b1;
        in_sign   = s;
        in_exp    = EXP_W'(e);
        in_q      = q;
        in_sticky = st;
        in_nan    = nan;
        in_inf    = inf;
        in_zero   = zero;
    endtask

    task automatic rand_beat();
        int          e;
        int          sel;
        logic [25:0] q;
        sel = $urandom_range(0, 9);
        if (sel == 0)      e = $urandom_range(0, 6) - 3;
        else if (sel == 1) e = $urandom_range(252, 258);
        else if (sel == 2) e = $urandom_range(0, 1023) - 512;
        else               e = $urandom_range(1, 254);
        sel = $urandom_range(0, 7);
        if (sel == 0)      q = 26'h3FF_FFFF;
        else if (sel == 1) q = 26'h1FF_FFFF;
        else if (sel < 5)  q = {1'b1, 25'($urandom)};
        else               q = {2'b01, 24'($urandom)};
        drive(1'($urandom), e, q, 1'($urandom),
              $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 15) == 0);
    endtask

    task automatic drain(input string nm);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && (sb.size() != 0 || out_valid); i++) tick();
        chk(nm, 64'(sb.size()), 64'(0));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready_low", 64'(in_ready), 64'(0));
        @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        sb.delete();
        prev_hold = 1'b0;
        acc_now   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        chk("post_rst_outputs", 64'({out_valid, obs}), 64'(0));
        @(negedge clk);
    endtask

    task automatic directed(input string nm, input logic s, input int e, input logic [25:0] q,
                            input logic st, input logic nan, input logic inf, input logic zero,
                            input logic [34:0] req);
        out_ready = 1'b1;
        drive(s, e, q, st, nan, inf, zero);
        tick();
        chk({nm, "_accept"}, 64'(acc_now), 64'(1));
        in_valid = 1'b0;
        #1;
        chk({nm, "_lat1"}, 64'(out_valid), 64'(0));
        tick();
        #1;
        chk({nm, "_lat2"}, 64'(out_valid), 64'(1));
        chk(nm, 64'(obs), 64'(req));
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        chk("pin_1_1",   64'(model(1'b0, 127, 26'h200_0000, 1'b0, 1'b0, 1'b0, 1'b0)),
            64'({3'b000, 32'h3F80_0000}));
        chk("pin_1_15",  64'(model(1'b0, 127, 26'h155_5555, 1'b1, 1'b0, 1'b0, 1'b0)),
            64'({3'b001, 32'h3F2A_AAAB}));
        chk("pin_ovf",   64'(model(1'b0, 254, 26'h3FF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0)),
            64'({3'b101, 32'h7F80_0000}));
        chk("pin_unf",   64'(model(1'b1, 1, 26'h100_0000, 1'b0, 1'b0, 1'b0, 1'b0)),
            64'({3'b011, 32'h8000_0000}));
        chk("pin_tie_even", 64'(model(1'b0, 128, 26'h100_0000 | 26'h1, 1'b0, 1'b0, 1'b0, 1'b0)),
            64'({3'b001, 32'h3F80_0000}));

        do_reset();

        directed("d_1_1",   1'b0, 127, 26'h200_0000, 1'b0, 1'b0, 1'b0, 1'b0, {3'b000, 32'h3F80_0000});
        directed("d_1_15",  1'b0, 127, 26'h155_5555, 1'b1, 1'b0, 1'b0, 1'b0, {3'b001, 32'h3F2A_AAAB});
        directed("d_ovf",   1'b0, 254, 26'h3FF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, {3'b101, 32'h7F80_0000});
        directed("d_unf",   1'b1, 1,   26'h100_0000, 1'b0, 1'b0, 1'b0, 1'b0, {3'b011, 32'h8000_0000});
        directed("d_naninf", 1'b1, 127, 26'h2AA_AAAA, 1'b1, 1'b1, 1'b1, 1'b0, {3'b000, 32'h7FC0_0000});
        directed("d_inf",   1'b1, 127, 26'h2AA_AAAA, 1'b1, 1'b0, 1'b1, 1'b0, {3'b000, 32'hFF80_0000});
        directed("d_zero",  1'b0, 3,   26'h2AA_AAAA, 1'b1, 1'b0, 1'b0, 1'b1, {3'b000, 32'h0000_0000});
        drain("drain_directed");

        out_ready = 1'b0;
        acc_cnt   = 0;
        acc_now   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!in_valid || acc_now) rand_beat();
            tick();
        end
        chk("bp_accepted", 64'(acc_cnt), 64'(2));
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        for (int i = 0; i < 3; i++) tick();
        chk("bp_still_two", 64'(acc_cnt), 64'(2));
        out_ready = 1'b1;
        for (int i = 0; i < 6 && !acc_now; i++) tick();
        chk("bp_third_accepted", 64'(acc_cnt), 64'(3));
        drain("drain_bp");

        acc_now = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || acc_now) begin
                if ($urandom_range(0, 3) != 0) rand_beat();
                else in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        out_ready = 1'b0;
        acc_now   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!in_valid || acc_now) rand_beat();
            tick();
        end
        do_reset();

        acc_now = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!in_valid || acc_now) begin
                if ($urandom_range(0, 3) != 0) rand_beat();
                else in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 9) < 5);
            tick();
        end
        drain("drain_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
